nbody_sequencer: RTL and testbench

//  Sequences one nbody simulation run: walks every (i,j) body pair into the getAccl pipeline,

---
 rtl/nbody_sequencer_if.sv | 38 +++
 rtl/nbody_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_nbody_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nbody_sequencer_if.sv
// rtl/nbody_sequencer_if.sv - control/status bundle between the bus wrapper and nbody_sequencer
// master: bus wrapper side (drives go/num_bodies/gap, observes all strobes and status)
// slave : sequencer side
interface nbody_sequencer_if #(
    parameter int BODY_ADDR_WIDTH = 9,
    parameter int GAP_WIDTH       = 32
);
    logic                       go;
    logic [BODY_ADDR_WIDTH:0]   num_bodies;
    logic [GAP_WIDTH-1:0]       gap;
    logic                       busy;
    logic                       done;
    logic                       cfg_err;
    logic [BODY_ADDR_WIDTH-1:0] rd_i;
    logic [BODY_ADDR_WIDTH-1:0] rd_j;
    logic                       pair_valid;
    logic                       acc_valid;
    logic                       acc_first;
    logic                       v_wr_en;
    logic [BODY_ADDR_WIDTH-1:0] acc_i;
    logic [BODY_ADDR_WIDTH-1:0] upd_rd_addr;
    logic                       upd_rd_en;
    logic                       upd_wr_en;
    logic [BODY_ADDR_WIDTH-1:0] upd_wr_addr;
    logic [GAP_WIDTH-1:0]       step_count;

    modport master (
        output go, num_bodies, gap,
        input  busy, done, cfg_err, rd_i, rd_j, pair_valid, acc_valid, acc_first,
               v_wr_en, acc_i, upd_rd_addr, upd_rd_en, upd_wr_en, upd_wr_addr, step_count
    );

    modport slave (
        input  go, num_bodies, gap,
        output busy, done, cfg_err, rd_i, rd_j, pair_valid, acc_valid, acc_first,
               v_wr_en, acc_i, upd_rd_addr, upd_rd_en, upd_wr_en, upd_wr_addr, step_count
    );
endinterface

// File: rtl/nbody_sequencer.sv
// rtl/nbody_sequencer.sv - nbody run sequencer: pair issue, getAccl tracking, position update sweep
// Ports: clk, rst (sync active-high), bus (nbody_sequencer_if.slave):
//   go/num_bodies/gap in; busy/done/cfg_err/step_count status; rd_i/rd_j/pair_valid pair reads;
//   acc_valid/acc_first/acc_i/v_wr_en accel results; upd_rd_*/upd_wr_* position update strobes.
module nbody_sequencer #(
    parameter int BODIES          = 512,
    parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
    parameter int ACCL_LATENCY    = 123,
    parameter int UPDATE_LATENCY  = 20,
    parameter int GAP_WIDTH       = 32
) (
    input  logic              clk,
    input  logic              rst,
    nbody_sequencer_if.slave  bus
);
    localparam int AW = BODY_ADDR_WIDTH;
    localparam int NW = BODY_ADDR_WIDTH + 1;
    // The extra stage accounts for the one-cycle RAM read ahead of getAccl / the adder.
    localparam int DA = ACCL_LATENCY + 1;
    localparam int DU = UPDATE_LATENCY + 1;

    localparam logic [NW-1:0]        N_ONE    = NW'(1);
    localparam logic [NW-1:0]        N_TWO    = NW'(2);
    localparam logic [NW-1:0]        N_MAX    = NW'(BODIES);
    localparam logic [AW-1:0]        A_ONE    = AW'(1);
    localparam logic [GAP_WIDTH-1:0] STEP_ONE = GAP_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0] STEP_MAX = '1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ACCEL     = 3'd1;
    localparam logic [2:0] S_DRAIN     = 3'd2;
    localparam logic [2:0] S_UPDATE    = 3'd3;
    localparam logic [2:0] S_UPD_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]           state, state_n;
    logic                 busy_q, done_q, cfg_err_q;
    logic [GAP_WIDTH-1:0] step_q, gap_q;
    logic [NW-1:0]        n_q;
    logic [AW-1:0]        pair_i, pair_j;
    logic                 pair_v;
    logic [AW-1:0]        upd_addr;
    logic                 upd_en;

    logic [DA-1:0]        a_valid, a_first, a_wr;
    logic [AW-1:0]        a_i [DA];
    logic [DU-1:0]        u_valid;
    logic [AW-1:0]        u_addr [DU];

    logic [NW-1:0] i_ext, j_ext, j_next, j_skip, n_m1, n_m2, ua_ext;
    logic          row_end, last_pair, pair_first, pair_last;
    logic          cfg_bad, running, abort, accel_empty, upd_empty, step_end, busy_n;

    always_comb begin
        i_ext   = {1'b0, pair_i};
        j_ext   = {1'b0, pair_j};
        ua_ext  = {1'b0, upd_addr};
        n_m1    = n_q - N_ONE;
        n_m2    = n_q - N_TWO;
        // Next j skips the diagonal in the same cycle, so no bubble appears.
        j_next  = j_ext + N_ONE;
        j_skip  = (j_next == i_ext) ? j_next + N_ONE : j_next;
        row_end   = (j_skip >= n_q);
        last_pair = row_end && (i_ext == n_m1);
        pair_first = (j_ext == '0) || ((j_ext == N_ONE) && (i_ext == '0));
        pair_last  = (j_ext == n_m1) || ((j_ext == n_m2) && (i_ext == n_m1));
        cfg_bad = (bus.num_bodies < N_TWO) || (bus.num_bodies > N_MAX);
        running = (state == S_ACCEL) || (state == S_DRAIN) ||
                  (state == S_UPDATE) || (state == S_UPD_DRAIN);
        abort   = running && !bus.go;
        // "Empty after this edge": only the output stage may still hold a result,
        // so the next phase starts the cycle right after the last strobe.
        accel_empty = ~|a_valid[DA-2:0];
        upd_empty   = ~|u_valid[DU-2:0];
        step_end    = (state == S_UPD_DRAIN) && upd_empty && !abort;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:      if (bus.go && !done_q) state_n = cfg_bad ? S_DONE : S_ACCEL;
            S_ACCEL:     if (last_pair) state_n = S_DRAIN;
            S_DRAIN:     if (accel_empty) state_n = S_UPDATE;
            S_UPDATE:    if (ua_ext == n_m1) state_n = S_UPD_DRAIN;
            S_UPD_DRAIN: if (upd_empty) state_n = (step_q == gap_q) ? S_DONE : S_ACCEL;
            S_DONE:      if (!bus.go) state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
        if (abort) state_n = S_IDLE;
        busy_n = (state_n == S_ACCEL) || (state_n == S_DRAIN) ||
                 (state_n == S_UPDATE) || (state_n == S_UPD_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            step_q    <= '0;
            gap_q     <= '0;
            n_q       <= '0;
            pair_i    <= '0;
            pair_j    <= '0;
            pair_v    <= 1'b0;
            upd_addr  <= '0;
            upd_en    <= 1'b0;
        end else begin
            state  <= state_n;
            busy_q <= busy_n;
            done_q <= (state_n == S_DONE);

            if ((state == S_IDLE) && (state_n != S_IDLE)) begin
                n_q       <= bus.num_bodies;
                gap_q     <= bus.gap;
                step_q    <= '0;
                cfg_err_q <= cfg_bad;
            end else if (step_end) begin
                step_q <= (step_q == STEP_MAX) ? STEP_MAX : step_q + STEP_ONE;
            end

            if (state_n == S_ACCEL) begin
                pair_v <= 1'b1;
                if (state != S_ACCEL) begin
                    pair_i <= '0;
                    pair_j <= A_ONE;
                end else if (row_end) begin
                    // A new row i>=1 always starts at j=0, which is never the diagonal.
                    pair_i <= pair_i + A_ONE;
                    pair_j <= '0;
                end else begin
                    pair_j <= j_skip[AW-1:0];
                end
            end else begin
                pair_v <= 1'b0;
                pair_i <= '0;
                pair_j <= '0;
            end

            if (state_n == S_UPDATE) begin
                upd_en   <= 1'b1;
                upd_addr <= (state == S_UPDATE) ? upd_addr + A_ONE : '0;
            end else begin
                upd_en   <= 1'b0;
                upd_addr <= '0;
            end
        end
    end

    // Delay lines shadow the getAccl pipeline and the update adder; an abort
    // flushes them so no stale writeback escapes after returning to IDLE.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            a_valid <= '0;
            a_first <= '0;
            a_wr    <= '0;
            u_valid <= '0;
            for (int k = 0; k < DA; k++) a_i[k] <= '0;
            for (int k = 0; k < DU; k++) u_addr[k] <= '0;
        end else begin
            a_valid <= {a_valid[DA-2:0], pair_v};
            a_first <= {a_first[DA-2:0], pair_v & pair_first};
            a_wr    <= {a_wr[DA-2:0], pair_v & pair_last};
            a_i[0]  <= pair_v ? pair_i : '0;
            for (int k = 1; k < DA; k++) a_i[k] <= a_i[k-1];
            u_valid   <= {u_valid[DU-2:0], upd_en};
            u_addr[0] <= upd_addr;
            for (int k = 1; k < DU; k++) u_addr[k] <= u_addr[k-1];
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.step_count  = step_q;
    assign bus.rd_i        = pair_i;
    assign bus.rd_j        = pair_j;
    assign bus.pair_valid  = pair_v;
    assign bus.acc_valid   = a_valid[DA-1];
    assign bus.acc_first   = a_first[DA-1];
    assign bus.v_wr_en     = a_wr[DA-1];
    assign bus.acc_i       = a_i[DA-1];
    assign bus.upd_rd_en   = upd_en;
    assign bus.upd_rd_addr = upd_addr;
    assign bus.upd_wr_en   = u_valid[DU-1];
    assign bus.upd_wr_addr = u_addr[DU-1];
endmodule

// File: tb/tb_nbody_sequencer.sv
// tb/tb_nbody_sequencer.sv - self-checking bench for nbody_sequencer
module tb_nbody_sequencer;
    localparam int BODIES  = 16;
    localparam int AW      = $clog2(BODIES);
    localparam int ACC_LAT = 123;
    localparam int UPD_LAT = 20;
    localparam int GW      = 32;
    localparam int DA      = ACC_LAT + 1;
    localparam int DU      = UPD_LAT + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nbody_sequencer_if #(.BODY_ADDR_WIDTH(AW), .GAP_WIDTH(GW)) bus ();

    nbody_sequencer #(
        .BODIES(BODIES), .BODY_ADDR_WIDTH(AW), .ACCL_LATENCY(ACC_LAT),
        .UPDATE_LATENCY(UPD_LAT), .GAP_WIDTH(GW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic          busy, done, cfg_err, pv;
        logic [AW-1:0] ri, rj;
        logic          av, af, vw;
        logic [AW-1:0] ai;
        logic          ure;
        logic [AW-1:0] ura;
        logic          uwe;
        logic [AW-1:0] uwa;
        logic [GW-1:0] step;
    } obs_t;

    typedef struct {
        int n; int gp; int abort_t; int rst_t;
        int pairs; int vws; int steps; int done;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.busy = bus.busy;        o.done = bus.done;       o.cfg_err = bus.cfg_err;
        o.pv   = bus.pair_valid;  o.ri = bus.rd_i;         o.rj = bus.rd_j;
        o.av   = bus.acc_valid;   o.af = bus.acc_first;    o.vw = bus.v_wr_en;
        o.ai   = bus.acc_i;       o.ure = bus.upd_rd_en;   o.ura = bus.upd_rd_addr;
        o.uwe  = bus.upd_wr_en;   o.uwa = bus.upd_wr_addr; o.step = bus.step_count;
        return o;
    endfunction

    // Pair number p within a step -> (i,j): N-1 partners per row, diagonal removed.
    task automatic pair_of(input int p, input int n, output int i, output int j);
        int jj;
        i  = p / (n - 1);
        jj = p % (n - 1);
        j  = (jj < i) ? jj : jj + 1;
    endtask

    // Expected outputs at t cycles after the first pair of a run, from the timeline:
    // pairs [0,M), results +DA, reads [M+DA, +N), writes +DU, next step right after.
    task automatic model(input int t, input int n, input int steps, input int abort_t,
                         output obs_t e, output obs_t m);
        int tb, per, mp, k, r, p, pi, pj;
        logic [GW-1:0] keep;
        bit ab;
        ab  = (abort_t >= 0) && (t > abort_t);
        tb  = ab ? abort_t : t;
        mp  = n * (n - 1);
        per = mp + DA + n + DU;
        e = '0;
        if (tb >= steps * per) begin
            e.done = 1'b1;
            e.step = GW'(steps);
        end else begin
            k = tb / per;
            r = tb % per;
            e.busy = 1'b1;
            e.step = GW'(k);
            if (r < mp) begin
                pair_of(r, n, pi, pj);
                e.pv = 1'b1; e.ri = AW'(pi); e.rj = AW'(pj);
            end
            p = r - DA;
            if (p >= 0 && p < mp) begin
                pair_of(p, n, pi, pj);
                e.av = 1'b1;
                e.ai = AW'(pi);
                e.af = (pj == 0) || (pj == 1 && pi == 0);
                e.vw = (pj == n - 1) || (pj == n - 2 && pi == n - 1);
            end
            p = r - mp - DA;
            if (p >= 0 && p < n) begin e.ure = 1'b1; e.ura = AW'(p); end
            p = r - mp - DA - DU;
            if (p >= 0 && p < n) begin e.uwe = 1'b1; e.uwa = AW'(p); end
        end
        if (ab) begin
            keep   = e.step;
            e      = '0;
            e.step = keep;
        end
        m = '1;
        if (!e.pv)  begin m.ri = '0; m.rj = '0; end
        if (!e.av)  begin m.ai = '0; m.af = 1'b0; end
        if (!e.ure) m.ura = '0;
        if (!e.uwe) m.uwa = '0;
    endtask

    task automatic run(input vec_t v);
        int steps, per, total, bad, first_bad, pairs, vws, t, rt;
        obs_t o, e, m, fo, fe;
        logic [AW-1:0] li, lj, lai;
        string tag;
        tag   = $sformatf("n=%0d gap=%0d ab=%0d rs=%0d", v.n, v.gp, v.abort_t, v.rst_t);
        steps = v.gp + 1;
        per   = v.n * (v.n - 1) + DA + v.n + DU;
        total = (v.abort_t >= 0) ? v.abort_t + 200 : steps * per + 4;
        bad = 0; first_bad = -1; pairs = 0; vws = 0; rt = v.rst_t;
        li = '0; lj = '0; lai = '0; fo = '0; fe = '0;
        bus.go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.num_bodies = (AW+1)'(v.n);
        bus.gap        = GW'(v.gp);
        bus.go         = 1'b1;
        t = 0;
        while (t <= total) begin
            @(negedge clk);
            o = sample();
            model(t, v.n, steps, v.abort_t, e, m);
            if (((o ^ e) & m) != '0) begin
                if (bad == 0) begin first_bad = t; fo = o; fe = e; end
                bad++;
            end
            if (o.pv) begin pairs++; li = o.ri; lj = o.rj; end
            if (o.vw) begin vws++; lai = o.ai; end
            // Inputs changed mid-run must be ignored; restored before any restart.
            if (t == 2) begin
                bus.num_bodies = (AW+1)'($urandom_range(31, 0));
                bus.gap        = GW'($urandom);
            end
            if (t == 4) begin
                bus.num_bodies = (AW+1)'(v.n);
                bus.gap        = GW'(v.gp);
            end
            if (t == v.abort_t) bus.go = 1'b0;
            if (t == rt) begin
                rst = 1'b1;
                @(negedge clk);
                check({"reset_mid_run ", tag}, 64'(sample()), 64'(0));
                rst = 1'b0;
                rt = -1; t = -1; pairs = 0; vws = 0;
            end
            t++;
        end
        check($sformatf("timeline %s first_bad_t=%0d got=%h want=%h", tag, first_bad, fo, fe),
              64'(bad), 64'(0));
        if (v.pairs >= 0) check({"pair_count ", tag}, 64'(pairs), 64'(v.pairs));
        if (v.vws >= 0)   check({"vwr_count ", tag}, 64'(vws), 64'(v.vws));
        check({"final_step ", tag}, 64'(o.step), 64'(v.steps));
        check({"final_done ", tag}, 64'(o.done), 64'(v.done));
        if (v.abort_t < 0) begin
            check({"last_pair ", tag}, 64'({li, lj}), 64'({AW'(v.n - 1), AW'(v.n - 2)}));
            check({"last_vwr_acc_i ", tag}, 64'(lai), 64'(v.n - 1));
        end
        bus.go = 1'b0;
        @(negedge clk);
        check({"release ", tag}, 64'({bus.done, bus.busy}), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int bads[4];
        int n, gp, per, ab, pvs;
        vec_t rv;
        //            n   gap abort rst  pairs vws steps done
        vecs[0] = '{  2,  0,  -1,   -1,    2,   2,  1,   1};
        vecs[1] = '{  4,  2,  -1,   -1,   36,  12,  3,   1};
        vecs[2] = '{  3,  0,  10,   -1,    6,   0,  0,   0};
        vecs[3] = '{ 16,  0,  -1,   -1,  240,  16,  1,   1};
        vecs[4] = '{  3,  1,  -1,  131,   12,   6,  2,   1};
        vecs[5] = '{  5,  1,  -1,   -1,   40,  10,  2,   1};
        bads = '{0, 1, BODIES + 1, 31};

        bus.go = 1'b0;
        bus.num_bodies = '0;
        bus.gap = '0;
        repeat (3) @(negedge clk);
        check("reset_state", 64'(sample()), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 64'(sample()), 64'(0));

        foreach (vecs[k]) run(vecs[k]);

        foreach (bads[k]) begin
            bus.go = 1'b0;
            @(negedge clk);
            bus.num_bodies = (AW+1)'(bads[k]);
            bus.go = 1'b1;
            @(negedge clk);
            check($sformatf("bad_n=%0d done/cfg_err/busy", bads[k]),
                  64'({bus.done, bus.cfg_err, bus.busy}), 64'(3'b110));
            pvs = 0;
            repeat (5) begin
                @(negedge clk);
                if (bus.pair_valid || bus.busy) pvs++;
            end
            check($sformatf("bad_n=%0d no_activity", bads[k]), 64'(pvs), 64'(0));
            bus.go = 1'b0;
            @(negedge clk);
            check($sformatf("bad_n=%0d release", bads[k]),
                  64'({bus.done, bus.cfg_err}), 64'(2'b01));
        end

        for (int r = 0; r < 6; r++) begin
            n   = $urandom_range(BODIES, 2);
            gp  = $urandom_range(2, 0);
            per = n * (n - 1) + DA + n + DU;
            ab  = ($urandom_range(2, 0) == 0) ? int'($urandom_range((gp + 1) * per - 1, 1)) : -1;
            if (ab < 0)
                rv = '{n, gp, -1, -1, (gp + 1) * n * (n - 1), (gp + 1) * n, gp + 1, 1};
            else
                rv = '{n, gp, ab, -1, -1, -1, ab / per, 0};
            run(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
